// File: rtl/pipeline_if_prefetch.sv
// Instruction-fetch prefetcher: issues in-order imem requests and queues returned instructions for decode.
// Latency: first instruction visible two cycles after its request handshake with a 1-cycle memory; no bypass.
// Backpressure: stall holds the head entry; new requests are throttled by queue credits and the in-flight cap.
module pipeline_if_prefetch #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            valid_IF,
  output logic [XLEN-1:0] pc_IF,
  output logic [31:0]     instruction_IF
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic [XLEN-1:0] q_pc  [FQ_DEPTH];
  logic [31:0]     q_ins [FQ_DEPTH];

  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Queue slots already owed to in-flight requests count against free space,
  // so a response always finds room and the queue cannot overflow.
  assign credit_sum     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !redirect_valid && (outstanding < MAX_C) &&
                          (credit_sum < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect targets are word aligned; low two bits are masked off.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Responses for requests issued before a redirect are dropped via discard.
  assign push = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop  = (count != '0) && !stall && !redirect_valid;

  assign valid_IF       = (count != '0);
  assign pc_IF          = valid_IF ? q_pc[head]  : '0;
  assign instruction_IF = valid_IF ? q_ins[head] : '0;

  // Fetch and response PC tracking; redirect restarts both at the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      rsp_pc   <= redirect_tgt;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
    end
  end

  // In-flight and discard accounting; after a redirect every request still in
  // flight (minus one answered this cycle) becomes stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid)
        discard <= outstanding - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

  // Queue occupancy and pointers; redirect empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (pop)  head <= head + AW'(1);
      if (push) tail <= tail + AW'(1);
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]  <= rsp_pc;
      q_ins[tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_pipeline_if_prefetch.sv
module tb_pipeline_if_prefetch;

  localparam int          XLEN = 64;
  localparam int          FQ   = 4;
  localparam int          MO   = 2;
  localparam logic [63:0] RPC  = 64'h0;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        valid_IF;
  logic [63:0] pc_IF;
  logic [31:0] instruction_IF;

  pipeline_if_prefetch #(
    .XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(FQ), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .valid_IF(valid_IF), .pc_IF(pc_IF), .instruction_IF(instruction_IF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory model: accepted requests with their due cycle and the epoch
  // (redirect/reset generation) in which they were issued.
  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } mreq_t;
  mreq_t mq[$];
  int    lat_lo = 1;
  int    lat_hi = 1;

  // Reference model: queue occupancy, next expected delivered PC and request address.
  int          occ   = 0;
  int          epoch = 0;
  logic [63:0] exp_pc;
  logic [63:0] exp_req;

  logic        s_valid, s_req_valid;
  logic [63:0] s_pc, s_req_addr;
  logic [31:0] s_ins;
  logic [63:0] popped[$];

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return (w * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample and check, then advance the model.
  task automatic tick();
    logic  hs, rsp, push, pop, exp_rv;
    mreq_t m;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ins_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_valid     = valid_IF;
    s_pc        = pc_IF;
    s_ins       = instruction_IF;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    exp_rv = !redirect_valid && (mq.size() < MO) && (occ + mq.size() < FQ);
    chk("req_valid", s_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", s_req_addr, exp_req);
    chk("valid_IF", s_valid, occ != 0);
    chk("pc_IF", s_pc, (occ != 0) ? exp_pc : 64'h0);
    chk("instr_IF", s_ins, (occ != 0) ? ins_of(exp_pc) : 32'h0);
    hs   = s_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    push = rsp && (mq[0].ep == epoch) && !redirect_valid;
    pop  = (occ != 0) && !stall && !redirect_valid;
    @(posedge clk);
    if (rsp) m = mq.pop_front();
    if (hs) begin
      m.addr = s_req_addr;
      m.due  = cyc + $urandom_range(lat_hi, lat_lo);
      m.ep   = epoch;
      mq.push_back(m);
    end
    if (redirect_valid) begin
      occ     = 0;
      epoch++;
      exp_pc  = redirect_pc & ~64'h3;
      exp_req = redirect_pc & ~64'h3;
    end else begin
      occ = occ + int'(push) - int'(pop);
      if (pop) exp_pc  = exp_pc + 64'd4;
      if (hs)  exp_req = exp_req + 64'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    chk("rst_valid_IF", valid_IF, 1'b0);
    chk("rst_pc_IF", pc_IF, 64'h0);
    chk("rst_instr_IF", instruction_IF, 32'h0);
    mq.delete();
    occ     = 0;
    epoch++;
    exp_pc  = RPC;
    exp_req = RPC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Run up to budget cycles, recording the PCs popped by decode.
  task automatic collect(input int k, input int budget);
    popped.delete();
    for (int i = 0; i < budget && popped.size() < k; i++) begin
      tick();
      if (s_valid && !stall && !redirect_valid) popped.push_back(s_pc);
    end
  endtask

  function automatic logic [63:0] got(input int i);
    return (popped.size() > i) ? popped[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    int first;
    int n;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    exp_pc         = RPC;
    exp_req        = RPC;
    @(negedge clk);

    // 1-cycle memory, free flowing: first request at RESET_PC, valid_IF two cycles later.
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        chk("first_req_valid", s_req_valid, 1'b1);
        chk("first_req_addr", s_req_addr, RPC);
      end
      if (s_valid && first < 0) first = i;
    end
    chk("first_valid_cycle", 64'(first), 64'd2);

    // Stall from reset: queue fills, requests stop, then drains in order.
    apply_reset();
    stall = 1'b1;
    repeat (6) tick();
    chk("full_req_valid", s_req_valid, 1'b0);
    chk("full_head_pc", s_pc, 64'h0);
    stall = 1'b0;
    collect(4, 4);
    for (int i = 0; i < 4; i++) chk("drain_pc", got(i), 64'(4 * i));

    // 3-cycle memory with two in flight, redirect to unaligned 0x103.
    lat_lo = 3; lat_hi = 3;
    apply_reset();
    tick();
    tick();
    tick();
    chk("two_inflight_block", s_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    tick();
    redirect_valid = 1'b0;
    collect(2, 20);
    chk("redir_pc0", got(0), 64'h100);
    chk("redir_pc1", got(1), 64'h104);

    // Redirect coinciding with a response and stall.
    lat_lo = 1; lat_hi = 1;
    apply_reset();
    stall = 1'b1;
    repeat (3) tick();
    n = 0;
    while (!(mq.size() > 0 && mq[0].due <= cyc) && n < 5) begin
      tick();
      n++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();
    chk("d_valid_after_redirect", s_valid, 1'b0);
    chk("d_req_valid", s_req_valid, 1'b1);
    chk("d_req_addr", s_req_addr, 64'h200);
    collect(1, 10);
    chk("d_first_pc", got(0), 64'h200);

    // Memory not ready for 5 cycles: address stable, nothing presented.
    apply_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("e_req_valid", s_req_valid, 1'b1);
      chk("e_addr_stable", s_req_addr, RPC);
      chk("e_no_valid", s_valid, 1'b0);
    end
    imem_req_ready = 1'b1;
    collect(2, 10);
    chk("e_resume_pc0", got(0), RPC);
    chk("e_resume_pc1", got(1), RPC + 64'd4);

    // Reset with three queued entries.
    apply_reset();
    stall = 1'b1;
    n = 0;
    while (occ != 3 && n < 20) begin
      tick();
      n++;
    end
    chk("f_valid_pre_reset", valid_IF, 1'b1);
    stall = 1'b0;
    apply_reset();
    tick();
    chk("f_post_req_valid", s_req_valid, 1'b1);
    chk("f_post_req_addr", s_req_addr, RPC);

    // Address wrap at the top of the PC space.
    lat_lo = 1; lat_hi = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF9;
    tick();
    redirect_valid = 1'b0;
    collect(3, 20);
    chk("wrap_pc0", got(0), 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_pc1", got(1), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc2", got(2), 64'h0);

    // Randomized traffic against the reference model.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(99) < 30);
      imem_req_ready = ($urandom_range(99) < 75);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = {$urandom, $urandom};
      tick();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_if_prefetch.md
PIPELINE_IF_PREFETCH -- requirements
Module: pipeline_if_prefetch

Interface
REQ-001 Parameter XLEN, 64, address/PC width.
REQ-002 Parameter RESET_PC, 64'h0, fetch address after reset.
REQ-003 Parameter FQ_DEPTH, 4, fetch-queue entries; power of two, >=2.
REQ-004 Parameter MAX_OUTST, 2, max memory requests in flight; 1..FQ_DEPTH.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stall  input  1  decode not accepting; head entry held.
REQ-008 redirect_valid  input  1  branch/jump redirect this cycle.
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 imem_req_valid  output  1  fetch request valid.
REQ-011 imem_req_ready  input  1  memory accepts request.
REQ-012 imem_req_addr  output  XLEN  fetch address.
REQ-013 imem_rsp_valid  input  1  in-order instruction return, one per accepted request, latency >=1 cycle.
REQ-014 imem_rsp_data  input  32  returned instruction.
REQ-015 valid_IF  output  1  pc_IF/instruction_IF valid.
REQ-016 pc_IF  output  XLEN  PC of presented instruction.
REQ-017 instruction_IF  output  32  presented instruction.

Function
REQ-018 The block SHALL hold fetch_pc, rsp_pc (PC of next expected response), queue count, outstanding count and discard count.
REQ-019 imem_req_valid SHALL be 1 iff !redirect_valid && outstanding < MAX_OUTST && (count + outstanding) < FQ_DEPTH; imem_req_addr = fetch_pc.
REQ-020 On req handshake fetch_pc SHALL advance by 4 (wrapping modulo 2^XLEN) and outstanding SHALL increment.
REQ-021 Each imem_rsp_valid SHALL decrement outstanding; if discard = 0 the data SHALL be pushed with tag rsp_pc and rsp_pc SHALL advance by 4; else discard SHALL decrement and data be dropped.
REQ-022 Queue SHALL be FIFO; push and pop in one cycle allowed; credit rule of REQ-019 SHALL make overflow impossible.
REQ-023 valid_IF = count != 0; pc_IF/instruction_IF SHALL show the head entry, and SHALL be 0 when count = 0.
REQ-024 Head SHALL pop on valid_IF && !stall && !redirect_valid; stall SHALL hold outputs stable.
REQ-025 Pushed entry SHALL appear at outputs no earlier than the cycle after imem_rsp_valid (no bypass).
REQ-026 On redirect_valid: queue emptied, fetch_pc and rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}, discard <= outstanding minus 1 if imem_rsp_valid same cycle; that response SHALL be dropped.
REQ-027 Redirect SHALL take priority over stall, pop and push; request issue resumes the cycle after.
REQ-028 Back-to-back redirects SHALL each restart from the latest target; discard SHALL track all in-flight requests.
REQ-029 imem_rsp_valid with outstanding = 0 is illegal; no behaviour required.

Reset
REQ-030 reset SHALL asynchronously set fetch_pc = rsp_pc = RESET_PC, count = outstanding = discard = 0, valid_IF = 0, pc_IF = 0, instruction_IF = 0.
REQ-031 Reset mid-operation SHALL discard queue and in-flight requests; memory responses for them after reset are the environment's responsibility.
REQ-032 First request SHALL issue in the first cycle after reset deasserts with addr RESET_PC.

Verification
REQ-033 1-cycle memory, ready=1, stall=0 -> addresses 0,4,8,..., valid_IF first high 2 cycles after reset release, then one instruction per cycle in order.
REQ-034 stall held 6 cycles -> queue fills to FQ_DEPTH=4, imem_req_valid drops, no entry lost; release -> 4 entries drain in order with PCs 0x0..0xC.
REQ-035 3-cycle memory, 2 in flight, redirect_pc=0x103 -> both stale responses dropped, next pc_IF = 0x100, then 0x104.
REQ-036 redirect_valid with imem_rsp_valid and stall same cycle -> response dropped, valid_IF=0 next cycle, fetch from target.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_req_addr stable, outstanding unchanged, no valid_IF glitch.
REQ-038 reset asserted with 3 queued entries -> valid_IF=0 immediately (async), first post-reset request addr = RESET_PC.
